pipe_generate: RTL and testbench

//  Producer of the three pipe descriptors consumed by the game FSM, crash checker and renderer.

---
 rtl/flappy_pkg.sv | 56 +++++
 rtl/pipe_lfsr.sv | 35 +++
 rtl/pipe_generate.sv | 144 ++++++++++++++
 tb/tb_pipe_generate.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared constants and types for the pipe game datapath.
// Screen geometry, pipe layout, gap sizing and the pipe scroll state encoding.
// Consumed by pipe_generate, the crash checker and the renderer.
package flappy_pkg;

   // Screen geometry
   localparam logic [11:0] H_ACTIVE     = 12'd640;
   localparam logic [11:0] V_ACTIVE     = 12'd480;

   // Pipe layout: x is the right edge, a pipe spans [x-PIPE_W, x)
   localparam int          NUM_PIPES    = 3;
   localparam logic [11:0] PIPE_W       = 12'd52;
   localparam logic [11:0] PIPE_SPACING = 12'd240;

   // Distance a respawned pipe jumps forward: behind the last of the three
   localparam logic [11:0] RESPAWN_DX   = 12'd720;

   // Gap geometry; GAP_HEIGHT is the opening size used by crash checker and renderer
   localparam logic [11:0] GAP_MIN      = 12'd80;
   localparam logic [11:0] GAP_RANGE    = 12'd240;
   localparam logic [11:0] GAP_INIT     = 12'd200;
   localparam logic [11:0] GAP_HEIGHT   = 12'd120;

   // Scroll speed in pixels per frame
   localparam logic [11:0] SPEED        = 12'd2;
   localparam logic [11:0] SPEED_MAX    = 12'd6;

   // Nonzero seed for the gap-height LFSR
   localparam logic [15:0] LFSR_SEED    = 16'hACE1;

   // Pipe scroll state encoding
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCROLL = 2'd1,
      FREEZE = 2'd2
   } pipe_state_t;

   // Map a random byte into [0, GAP_RANGE); single subtraction suffices since GAP_RANGE > 128
   function automatic logic [11:0] fold_gap(input logic [7:0] r);
      logic [11:0] r_w;
      r_w = {4'd0, r};
      if (r_w < GAP_RANGE) begin
         fold_gap = r_w;
      end else begin
         fold_gap = r_w - GAP_RANGE;
      end
   endfunction

   // Start-of-game right-edge x of pipe index k (0-based)
   function automatic logic [11:0] pipe_start_x(input int k);
      logic [11:0] k_w;
      k_w = 12'(k);
      pipe_start_x = H_ACTIVE + PIPE_W + k_w * PIPE_SPACING;
   endfunction

endpackage

// File: rtl/pipe_lfsr.sv
// Free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11) supplying gap-height randomness.
// Latency: advances one step every clk; out is the current register value.
// Backpressure: none, never stalls; the seed is reloaded only by rst.
module pipe_lfsr #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] out
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_nxt;

   // Shift right; when the bit falling out is 1, fold it back into the tap positions
   always_comb begin
      lfsr_nxt        = {1'b0, lfsr_q[15:1]};
      lfsr_nxt[15]    = lfsr_q[0];
      lfsr_nxt[13]    = lfsr_q[14] ^ lfsr_q[0];
      lfsr_nxt[12]    = lfsr_q[13] ^ lfsr_q[0];
      lfsr_nxt[10]    = lfsr_q[11] ^ lfsr_q[0];
   end

   // State register; a nonzero seed keeps the sequence out of the all-zero lockup
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_nxt;
      end
   end

   assign out = lfsr_q;

endmodule

// File: rtl/pipe_generate.sv
// Produces three scrolling pipe descriptors (right-edge x, gap-top y) for FSM, crash checker, renderer.
// Latency: positions update on the clk edge where the vs rising-edge tick is high; state changes take 1 clk.
// Backpressure: none; frozen in FREEZE, start layout in IDLE. Optional speed-up via PIPE_SPEEDUP_EN.
module pipe_generate
   import flappy_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        vs,
   input  logic        waiting,
   input  logic        play,
   input  logic        over,
   input  logic [11:0] score,
   output logic [11:0] pipe1_x,
   output logic [11:0] pipe1_y,
   output logic [11:0] pipe2_x,
   output logic [11:0] pipe2_y,
   output logic [11:0] pipe3_x,
   output logic [11:0] pipe3_y
);

   pipe_state_t state;
   pipe_state_t state_nxt;
   logic        vs_d;
   logic        tick;
   logic        load_init;
   logic        scroll_en;
   logic [11:0] spd;
   logic [15:0] lfsr;

   // Delay vs by one clk so a frame tick is exactly one clk wide per vs rising edge
   always_ff @(posedge clk) begin
      if (rst) begin
         vs_d <= 1'b0;
      end else begin
         vs_d <= vs;
      end
   end

   assign tick = vs & ~vs_d;

   pipe_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk (clk),
      .rst (rst),
      .out (lfsr)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: each state leaves only on its own flag, otherwise holds
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (play)    state_nxt = SCROLL;
         SCROLL:  if (over)    state_nxt = FREEZE;
         FREEZE:  if (waiting) state_nxt = IDLE;
         default:              state_nxt = IDLE;
      endcase
   end

   // Decoded controls: IDLE reloads the start layout, SCROLL moves on ticks, FREEZE holds
   always_comb begin
      load_init = 1'b0;
      scroll_en = 1'b0;
      case (state)
         IDLE:    load_init = 1'b1;
         SCROLL:  scroll_en = 1'b1;
         FREEZE:  ;
         default: load_init = 1'b1;
      endcase
   end

`ifdef PIPE_SPEEDUP_EN
   logic [11:0] spd_q;
   logic [11:0] spd_cap;

   // Target speed grows by one for every 8 points, capped at SPEED_MAX
   always_comb begin
      spd_cap = SPEED + {3'd0, score[11:3]};
      if (spd_cap > SPEED_MAX) begin
         spd_cap = SPEED_MAX;
      end
   end

   // Latch the target on each tick so a speed change only applies from the next frame
   always_ff @(posedge clk) begin
      if (rst) begin
         spd_q <= SPEED;
      end else if (tick) begin
         spd_q <= spd_cap;
      end
   end

   assign spd = spd_q;
`else
   logic unused_score;

   assign spd          = SPEED;
   assign unused_score = ^score;
`endif

   // One identical update per pipe; each pipe draws a different LFSR byte so simultaneous respawns differ
   for (genvar k = 0; k < NUM_PIPES; k++) begin : g_pipe
      localparam logic [11:0] START_X = pipe_start_x(k);

      logic [11:0] x_r;
      logic [11:0] y_r;
      logic [7:0]  rnd;

      assign rnd = lfsr[4*k +: 8];

      // Scroll left by spd each tick; a pipe that would leave the screen jumps behind the last one
      always_ff @(posedge clk) begin
         if (rst || load_init) begin
            x_r <= START_X;
            y_r <= GAP_INIT;
         end else if (scroll_en && tick) begin
            if (x_r > spd) begin
               x_r <= x_r - spd;
            end else begin
               x_r <= x_r - spd + RESPAWN_DX;
               y_r <= GAP_MIN + fold_gap(rnd);
            end
         end
      end
   end

   assign pipe1_x = g_pipe[0].x_r;
   assign pipe1_y = g_pipe[0].y_r;
   assign pipe2_x = g_pipe[1].x_r;
   assign pipe2_y = g_pipe[1].y_r;
   assign pipe3_x = g_pipe[2].x_r;
   assign pipe3_y = g_pipe[2].y_r;

endmodule

// File: tb/tb_pipe_generate.sv
// Self-checking bench for pipe_generate: directed scenarios plus randomized flags/vs/reset.
// A frame-level model predicts all six outputs; a compare process checks them every cycle.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
module tb_pipe_generate;

   logic        clk;
   logic        rst;
   logic        vs;
   logic        waiting;
   logic        play;
   logic        over;
   logic [11:0] score;
   logic [11:0] pipe1_x, pipe1_y, pipe2_x, pipe2_y, pipe3_x, pipe3_y;

   int vec_cnt;
   int err_cnt;

   pipe_generate dut (
      .clk     (clk),
      .rst     (rst),
      .vs      (vs),
      .waiting (waiting),
      .play    (play),
      .over    (over),
      .score   (score),
      .pipe1_x (pipe1_x),
      .pipe1_y (pipe1_y),
      .pipe2_x (pipe2_x),
      .pipe2_y (pipe2_y),
      .pipe3_x (pipe3_x),
      .pipe3_y (pipe3_y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // mode: 0 = waiting for play, 1 = scrolling, 2 = frozen
   int          m_x [3];
   int          m_y [3];
   int          m_mode;
   int          m_spd;
   bit          m_vs_prev;
   bit          m_valid;
   logic [15:0] m_lfsr;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      logic [15:0] n;
      n = v >> 1;
      if (v[0]) n = n ^ 16'hB400;
      return n;
   endfunction

   function automatic int fold(input int r);
      return (r < 240) ? r : r - 240;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 3; k++) begin
            m_x[k] = 692 + 240 * k;
            m_y[k] = 200;
         end
         m_mode    = 0;
         m_spd     = 2;
         m_vs_prev = 1'b0;
         m_lfsr    = 16'hACE1;
         m_valid   = 1'b1;
      end else begin
         bit frame;
         frame = vs && !m_vs_prev;
         if (m_mode == 0) begin
            for (int k = 0; k < 3; k++) begin
               m_x[k] = 692 + 240 * k;
               m_y[k] = 200;
            end
         end else if (m_mode == 1 && frame) begin
            for (int k = 0; k < 3; k++) begin
               if (m_x[k] > m_spd) begin
                  m_x[k] = m_x[k] - m_spd;
               end else begin
                  m_x[k] = m_x[k] - m_spd + 720;
                  m_y[k] = 80 + fold(int'((m_lfsr >> (4 * k)) & 16'h00FF));
               end
            end
         end
`ifdef PIPE_SPEEDUP_EN
         if (frame) begin
            m_spd = 2 + int'(score >> 3);
            if (m_spd > 6) m_spd = 6;
         end
`endif
         case (m_mode)
            0: if (play)    m_mode = 1;
            1: if (over)    m_mode = 2;
            default: if (waiting) m_mode = 0;
         endcase
         m_lfsr    = lfsr_step(m_lfsr);
         m_vs_prev = vs;
      end
   end

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (m_valid) begin
         vec_cnt++;
         if (pipe1_x !== 12'(m_x[0]) || pipe1_y !== 12'(m_y[0]) ||
             pipe2_x !== 12'(m_x[1]) || pipe2_y !== 12'(m_y[1]) ||
             pipe3_x !== 12'(m_x[2]) || pipe3_y !== 12'(m_y[2])) begin
            err_cnt++;
            $display("FAIL model_cmp t=%0t got x=%0d/%0d/%0d y=%0d/%0d/%0d want x=%0d/%0d/%0d y=%0d/%0d/%0d",
                     $time, pipe1_x, pipe2_x, pipe3_x, pipe1_y, pipe2_y, pipe3_y,
                     m_x[0], m_x[1], m_x[2], m_y[0], m_y[1], m_y[2]);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input int act, input int exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic do_tick(input int hi, input int lo);
      @(negedge clk);
      vs = 1'b1;
      repeat (hi) @(negedge clk);
      vs = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic chk_layout(input string nm, input int x1, input int x2, input int x3);
      chk({nm, "_x1"}, int'(pipe1_x), x1);
      chk({nm, "_x2"}, int'(pipe2_x), x2);
      chk({nm, "_x3"}, int'(pipe3_x), x3);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      m_valid = 1'b0;
      rst     = 1'b1;
      vs      = 1'b0;
      waiting = 1'b0;
      play    = 1'b0;
      over    = 1'b0;
      score   = 12'd0;

      // Pin the model's LFSR step and gap folding to hand-computed values
      chk("model_lfsr_1", int'(lfsr_step(16'hACE1)), 32'hE270);
      chk("model_lfsr_2", int'(lfsr_step(16'hE270)), 32'h7138);
      chk("model_fold_F5", 80 + fold(8'hF5), 85);
      chk("model_fold_10", 80 + fold(8'h10), 96);

      // Reset layout
      repeat (2) @(negedge clk);
      chk_layout("reset", 692, 932, 1172);
      chk("reset_y1", int'(pipe1_y), 200);
      chk("reset_y3", int'(pipe3_y), 200);
      rst = 1'b0;

      // No motion while play is low
      repeat (3) do_tick(3, 3);
      chk_layout("idle_ticks", 692, 932, 1172);

      // Ten slow frames of scrolling
      play = 1'b1;
      repeat (10) do_tick(50, 50);
      chk_layout("ten_ticks", 672, 912, 1152);

      // Scroll pipe 1 down to x=2, then respawn it
      for (int i = 0; i < 400 && pipe1_x != 12'd2; i++) do_tick(2, 2);
      chk_layout("pre_respawn", 2, 242, 482);
      do_tick(2, 2);
      chk_layout("respawn", 720, 240, 480);
      vec_cnt++;
      if (pipe1_y < 12'd80 || pipe1_y >= 12'd320) begin
         err_cnt++;
         $display("FAIL respawn_y_range got %0d want 80..319", pipe1_y);
      end

      // Game over freezes everything
      over = 1'b1;
      @(negedge clk);
      over = 1'b0;
      repeat (5) do_tick(2, 2);
      chk_layout("frozen", 720, 240, 480);

      // Waiting restores the start layout within 2 clk
      waiting = 1'b1;
      repeat (2) @(negedge clk);
      waiting = 1'b0;
      chk_layout("restore", 692, 932, 1172);

      // Scroll a bit, then reset mid-game
      repeat (3) do_tick(2, 2);
      chk_layout("rescroll", 686, 926, 1166);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_layout("mid_rst", 692, 932, 1172);
      chk("mid_rst_y2", int'(pipe2_y), 200);

`ifdef PIPE_SPEEDUP_EN
      // Speed follows score/8 from the tick after it is sampled, capped at 6
      score = 12'd16;
      do_tick(2, 2);
      do_tick(2, 2);
      chk("speed_4", int'(pipe1_x), 686);
      score = 12'd200;
      do_tick(2, 2);
      do_tick(2, 2);
      chk("speed_cap", int'(pipe1_x), 676);
      score = 12'd0;
`endif

      // Randomized flags, frame timing and occasional reset
      play = 1'b1;
      for (int c = 0; c < 8000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 2) == 0) vs = ~vs;
         play    = ($urandom_range(0, 3) != 0);
         over    = ($urandom_range(0, 999) == 0);
         waiting = ($urandom_range(0, 39) == 0);
         rst     = ($urandom_range(0, 2499) == 0);
         if ($urandom_range(0, 199) == 0) score = 12'($urandom_range(0, 4095));
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
